// File: rtl/cs_quantization_if.sv
// Handshake bundle for cs_quantization: a sample stream in, one quantized packet out.
// The slave modport is the quantizer; the master modport is the producer/consumer side.
interface cs_quantization_if #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned PACKET_LEN      = 128,
    parameter int unsigned BIT_SHIFT_WIDTH = 4
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH-1:0]      in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [PACKET_LEN-1:0]      y_p;
    logic [BIT_SHIFT_WIDTH-1:0] bit_shift;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, y_p, bit_shift
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, y_p, bit_shift
    );
endinterface

// File: rtl/cs_quantization.sv
// Collects REG_BANK_DEPTH unsigned samples, picks one right-shift that fits the largest
// sample into Q_WIDTH bits, and emits every lane shifted (optionally rounded) and saturated.
module cs_quantization #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned REG_BANK_DEPTH  = 8,
    parameter int unsigned PACKET_LEN      = DATA_WIDTH * REG_BANK_DEPTH,
    parameter int unsigned BIT_SHIFT_WIDTH = 4,
    parameter int unsigned Q_WIDTH         = 8,
    parameter int unsigned ROUND           = 1
) (
    input logic               clk,
    input logic               rst,
    cs_quantization_if.slave  bus
);
    localparam int unsigned CntW     = (REG_BANK_DEPTH > 1) ? $clog2(REG_BANK_DEPTH) : 1;
    localparam int unsigned ExtW     = DATA_WIDTH + 1;
    localparam int unsigned ShiftMax = (1 << BIT_SHIFT_WIDTH) - 1;
    localparam logic [CntW-1:0] CntLast = CntW'(REG_BANK_DEPTH - 1);
    localparam logic [ExtW-1:0] QMax    = ExtW'((64'd1 << Q_WIDTH) - 64'd1);

    typedef enum logic [1:0] {StCollect, StCalc, StOut} state_e;

    state_e                     state_q, state_d;
    logic [CntW-1:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      acc_or_q, acc_or_d;
    logic [DATA_WIDTH-1:0]      lane_q [REG_BANK_DEPTH];
    logic [DATA_WIDTH-1:0]      lane_d [REG_BANK_DEPTH];
    logic                       out_valid_q, out_valid_d;
    logic [PACKET_LEN-1:0]      y_p_q, y_p_d;
    logic [BIT_SHIFT_WIDTH-1:0] bit_shift_q, bit_shift_d;

    logic [BIT_SHIFT_WIDTH-1:0] shift;
    logic [PACKET_LEN-1:0]      packed_y;

    // Shift so that the widest sample (msb+1 bits) just fits into Q_WIDTH bits.
    always_comb begin
        int unsigned nbits;
        int unsigned shift_full;
        nbits = 0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (acc_or_q[i]) nbits = i + 1;
        end
        shift_full = (nbits > Q_WIDTH) ? nbits - Q_WIDTH : 0;
        if (shift_full > ShiftMax) shift_full = ShiftMax;
        shift = BIT_SHIFT_WIDTH'(shift_full);
    end

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        logic [ExtW-1:0] ext;
        packed_y = '0;
        ext      = '0;
        for (int unsigned i = 0; i < REG_BANK_DEPTH; i++) begin
            ext = {1'b0, lane_q[i]};
            if (ROUND != 0 && shift != '0) ext = ext + (ExtW'(1) << (shift - 1'b1));
            ext = ext >> shift;
            if (ext > QMax) ext = QMax;
            packed_y[DATA_WIDTH*i +: DATA_WIDTH] = ext[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_or_d    = acc_or_q;
        lane_d      = lane_q;
        out_valid_d = out_valid_q;
        y_p_d       = y_p_q;
        bit_shift_d = bit_shift_q;
        unique case (state_q)
            StCollect: begin
                if (bus.in_valid) begin
                    lane_d[cnt_q] = bus.in_data;
                    acc_or_d      = acc_or_q | bus.in_data;
                    if (cnt_q == CntLast) begin
                        cnt_d   = '0;
                        state_d = StCalc;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StCalc: begin
                y_p_d       = packed_y;
                bit_shift_d = shift;
                out_valid_d = 1'b1;
                state_d     = StOut;
            end
            StOut: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_or_d    = '0;
                    state_d     = StCollect;
                end
            end
            default: state_d = StCollect;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StCollect;
            cnt_q       <= '0;
            acc_or_q    <= '0;
            out_valid_q <= 1'b0;
            y_p_q       <= '0;
            bit_shift_q <= '0;
            for (int unsigned i = 0; i < REG_BANK_DEPTH; i++) lane_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_or_q    <= acc_or_d;
            out_valid_q <= out_valid_d;
            y_p_q       <= y_p_d;
            bit_shift_q <= bit_shift_d;
            lane_q      <= lane_d;
        end
    end

    assign bus.in_ready  = (state_q == StCollect) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.y_p       = y_p_q;
    assign bus.bit_shift = bit_shift_q;
endmodule

// File: tb/tb_cs_quantization.sv
// Directed bench: a rounding and a truncating quantizer see identical stimulus and are
// checked against hand-computed packets.
module tb_cs_quantization;
    typedef logic [15:0] lanes_t [8];

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic out_ready = 1'b0;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cs_quantization_if #(.DATA_WIDTH(16), .PACKET_LEN(128), .BIT_SHIFT_WIDTH(4)) if_r ();
    cs_quantization_if #(.DATA_WIDTH(16), .PACKET_LEN(128), .BIT_SHIFT_WIDTH(4)) if_t ();

    assign if_r.in_valid  = in_valid;
    assign if_r.in_data   = in_data;
    assign if_r.out_ready = out_ready;
    assign if_t.in_valid  = in_valid;
    assign if_t.in_data   = in_data;
    assign if_t.out_ready = out_ready;

    cs_quantization #(.ROUND(1)) u_dut_r (.clk(clk), .rst(rst), .bus(if_r));
    cs_quantization #(.ROUND(0)) u_dut_t (.clk(clk), .rst(rst), .bus(if_t));

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pack(input lanes_t l);
        logic [127:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[16*i +: 16] = l[i];
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample and wait (bounded) until it is taken.
    task automatic push(input logic [15:0] d);
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        while (!if_r.in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (waited >= 50) check_eq("push_timeout", 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_packet(input string tag, input lanes_t s, input lanes_t exp_r,
                              input lanes_t exp_t, input logic [3:0] sh_r,
                              input logic [3:0] sh_t);
        for (int i = 0; i < 8; i++) push(s[i]);
        check_eq({tag, "_valid_n1"}, if_r.out_valid, 1'b0);
        check_eq({tag, "_ready_calc"}, if_r.in_ready, 1'b0);
        step();
        check_eq({tag, "_valid_n2"}, if_r.out_valid, 1'b1);
        check_eq({tag, "_shift_r"}, if_r.bit_shift, sh_r);
        check_eq({tag, "_yp_r"}, if_r.y_p, pack(exp_r));
        check_eq({tag, "_shift_t"}, if_t.bit_shift, sh_t);
        check_eq({tag, "_yp_t"}, if_t.y_p, pack(exp_t));
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq({tag, "_valid_clr"}, if_r.out_valid, 1'b0);
        check_eq({tag, "_ready_back"}, if_r.in_ready, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        lanes_t s, er, et;
        logic [127:0] held;

        step();
        step();
        check_eq("rst_in_ready", if_r.in_ready, 1'b0);
        check_eq("rst_out_valid", if_r.out_valid, 1'b0);
        check_eq("rst_y_p", if_r.y_p, '0);
        check_eq("rst_bit_shift", if_r.bit_shift, '0);
        rst = 1'b0;
        #1;
        check_eq("rst_release_ready", if_r.in_ready, 1'b1);

        s = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
        run_packet("small", s, s, s, 4'd0, 4'd0);
        pop("small");

        s  = '{16'h1234, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010};
        er = '{16'h0092, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
        et = '{16'h0091, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_packet("mixed", s, er, et, 4'd5, 4'd5);
        pop("mixed");

        s  = '{default: 16'hFFFF};
        er = '{default: 16'h00FF};
        run_packet("full", s, er, er, 4'd8, 4'd8);
        pop("full");

        s = '{default: 16'h0000};
        run_packet("zero", s, s, s, 4'd0, 4'd0);
        pop("zero");

        // Backpressure: producer keeps offering a sample while the packet is unconsumed.
        s = '{16'd100, 16'd110, 16'd120, 16'd130, 16'd140, 16'd150, 16'd160, 16'd170};
        run_packet("hold", s, s, s, 4'd0, 4'd0);
        held = if_r.y_p;
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("hold_in_ready", if_r.in_ready, 1'b0);
            check_eq("hold_y_p", if_r.y_p, pack(s));
        end
        check_eq("hold_valid", if_r.out_valid, 1'b1);
        pop("hold");
        s  = '{16'hABCD, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7};
        er = '{16'h00AC, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        et = '{16'h00AB, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_packet("after_hold", s, er, et, 4'd8, 4'd8);
        pop("after_hold");

        // Mid-packet reset must drop the three large samples and their OR history.
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'hFFFF);
        rst = 1'b1;
        step();
        check_eq("midrst_in_ready", if_r.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("midrst_out_valid", if_r.out_valid, 1'b0);
        s = '{16'd10, 16'd11, 16'd12, 16'd13, 16'd14, 16'd15, 16'd16, 16'd17};
        run_packet("midrst", s, s, s, 4'd0, 4'd0);
        pop("midrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cs_quantization.md
CS_QUANTIZATION -- requirements
Module: cs_quantization

Interface
REQ-001 Parameter DATA_WIDTH, 16, width of one measurement sample and of one output lane.
REQ-002 Parameter REG_BANK_DEPTH, 8, number of samples per packet.
REQ-003 Parameter PACKET_LEN, DATA_WIDTH*REG_BANK_DEPTH, width of the packed output.
REQ-004 Parameter BIT_SHIFT_WIDTH, 4, width of the shift field.
REQ-005 Parameter Q_WIDTH, 8, number of significant bits kept per lane after quantization.
REQ-006 Parameter ROUND, 1, 1 = round-half-up before shifting, 0 = truncate.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 in_valid  input  1  in_data holds a valid unsigned sample.
REQ-010 in_ready  output  1  block accepts a sample this cycle.
REQ-011 in_data  input  DATA_WIDTH  unsigned measurement sample.
REQ-012 out_valid  output  1  y_p and bit_shift hold a complete packet.
REQ-013 out_ready  input  1  downstream dequantizer consumes the packet.
REQ-014 y_p  output  PACKET_LEN  quantized lanes; lane i at bits [DATA_WIDTH*i +: DATA_WIDTH], zero-extended.
REQ-015 bit_shift  output  BIT_SHIFT_WIDTH  right-shift applied to every lane of the packet.

Function
REQ-016 FSM states are COLLECT, CALC and OUT; the reset state is COLLECT.
REQ-017 In COLLECT, in_ready SHALL be 1; a transfer occurs when in_valid&&in_ready.
REQ-018 Each transfer writes in_data to lane cnt, increments cnt, and ORs in_data into acc_or.
REQ-019 A transfer with cnt==REG_BANK_DEPTH-1 wraps cnt to 0 and moves the FSM to CALC.
REQ-020 In CALC (exactly one cycle), in_ready=0; msb = index of the highest set bit of acc_or, or -1 if acc_or==0.
REQ-021 shift = max(0, msb+1-Q_WIDTH), clamped to 2^BIT_SHIFT_WIDTH-1.
REQ-022 For each lane, ROUND=1 computes (lane + (shift>0 ? 2^(shift-1) : 0)) >> shift at DATA_WIDTH+1 bits; ROUND=0 computes lane >> shift.
REQ-023 Each lane result SHALL saturate to 2^Q_WIDTH-1, then be zero-extended to DATA_WIDTH.
REQ-024 At the end of CALC, y_p and bit_shift are registered, out_valid is set, and the FSM moves to OUT.
REQ-025 In OUT, out_valid=1 and in_ready=0; y_p and bit_shift SHALL stay stable until out_valid&&out_ready.
REQ-026 On out_valid&&out_ready, out_valid clears, acc_or clears to 0, and the FSM returns to COLLECT; in_ready is 1 the next cycle.
REQ-027 Latency: the last sample is accepted in cycle N; out_valid is first high in cycle N+2.
REQ-028 Packets do not overlap; in_data presented while in_ready=0 SHALL be ignored and left unconsumed.
REQ-029 out_ready is ignored while out_valid=0.
REQ-030 y_p and bit_shift change only on CALC exit or reset.

Reset
REQ-031 While rst=1 at a clock edge: state=COLLECT, cnt=0, acc_or=0, out_valid=0, y_p=0, bit_shift=0.
REQ-032 While rst=1, in_ready=0; it becomes 1 in the first cycle after rst deasserts.
REQ-033 Reset mid-packet or in OUT discards all partial or pending data; the next accepted sample goes to lane 0.
REQ-034 rst has priority over every transfer in the same cycle.

Verification
REQ-035 All 8 samples ≤255 (e.g. 0..7) -> bit_shift=0, each lane equals its input, out_valid at N+2.
REQ-036 Lane0=0x1234, others 0x0010, ROUND=1 -> bit_shift=5, lane0=0x0092, others 0x0001; with ROUND=0 -> lane0=0x0091, others 0x0000.
REQ-037 All samples 0xFFFF, ROUND=1 -> bit_shift=8, every lane saturates to 0x00FF.
REQ-038 All samples 0 -> bit_shift=0, y_p=0.
REQ-039 Hold out_ready=0 for 10 cycles while driving in_valid=1 -> in_ready=0, y_p stable, no sample consumed; after out_ready=1, the next sample lands in lane 0.
REQ-040 Assert rst for 1 cycle after 3 accepted samples, then send 8 new samples -> the packet contains only the new samples, and bit_shift reflects only those.
